// File: rtl/mem_arbiter_if.sv
// Bundles the load, store, response and memory-side signals of the data-memory arbiter.
// Names carry i_/o_ as seen from the arbiter; the slave modport is the arbiter side.
interface mem_arbiter_if #(
  parameter int TAG_W = 3
);
  logic             i_flush;
  logic             i_ld_valid;
  logic             o_ld_ready;
  logic [7:0]       i_ld_addr;
  logic [TAG_W-1:0] i_ld_tag;
  logic             i_st_valid;
  logic             o_st_ready;
  logic [7:0]       i_st_addr;
  logic [7:0]       i_st_data;
  logic             o_ld_resp_valid;
  logic [TAG_W-1:0] o_ld_resp_tag;
  logic [7:0]       o_ld_resp_data;
  logic             o_mem_en;
  logic             o_mem_wr;
  logic [7:0]       o_mem_addr;
  logic [7:0]       o_mem_wdata;
  logic [7:0]       i_mem_rdata;

  modport slave (
    input  i_flush, i_ld_valid, i_ld_addr, i_ld_tag,
    input  i_st_valid, i_st_addr, i_st_data, i_mem_rdata,
    output o_ld_ready, o_st_ready, o_ld_resp_valid, o_ld_resp_tag, o_ld_resp_data,
    output o_mem_en, o_mem_wr, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_flush, i_ld_valid, i_ld_addr, i_ld_tag,
    output i_st_valid, i_st_addr, i_st_data, i_mem_rdata,
    input  o_ld_ready, o_st_ready, o_ld_resp_valid, o_ld_resp_tag, o_ld_resp_data,
    input  o_mem_en, o_mem_wr, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter: load-favoured grant with store anti-starvation and
// same-address ordering, plus the one-cycle tagged load response path.
module mem_arbiter #(
  parameter int TAG_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave io_bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_rd_pend;
  logic [TAG_W-1:0] r_rd_tag;

  logic w_st_wins;
  logic w_st_fire;
  logic w_ld_fire;
  logic w_resp_valid;

  // An older store to the same address must reach memory before the load reads it.
  assign w_st_wins = io_bus.i_st_valid &
                     ((r_starve_cnt == LIMIT) | ~io_bus.i_ld_valid |
                      (io_bus.i_ld_addr == io_bus.i_st_addr) | io_bus.i_flush);

  assign w_st_fire = ~rst & w_st_wins;
  assign w_ld_fire = ~rst & io_bus.i_ld_valid & ~io_bus.i_flush & ~w_st_wins;

  assign io_bus.o_st_ready  = w_st_fire;
  assign io_bus.o_ld_ready  = w_ld_fire;
  assign io_bus.o_mem_en    = w_st_fire | w_ld_fire;
  assign io_bus.o_mem_wr    = w_st_fire;
  assign io_bus.o_mem_addr  = w_st_fire ? io_bus.i_st_addr :
                              w_ld_fire ? io_bus.i_ld_addr : 8'h00;
  assign io_bus.o_mem_wdata = w_st_fire ? io_bus.i_st_data : 8'h00;

  // Reset gates the response too, so a load fired just before reset never returns.
  assign w_resp_valid           = r_rd_pend & ~io_bus.i_flush & ~rst;
  assign io_bus.o_ld_resp_valid = w_resp_valid;
  assign io_bus.o_ld_resp_tag   = rst ? '0 : r_rd_tag;
  assign io_bus.o_ld_resp_data  = w_resp_valid ? io_bus.i_mem_rdata : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_st_fire || !io_bus.i_st_valid) begin
      r_starve_cnt <= '0;
    end else if (w_ld_fire && r_starve_cnt != LIMIT) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rd_tag  <= '0;
    end else begin
      r_rd_pend <= w_ld_fire;
      if (w_ld_fire) begin
        r_rd_tag <= io_bus.i_ld_tag;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory of one-cycle read latency.
module tb_mem_arbiter;
  localparam int TAG_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   assertCount = 0;
  int   failCount   = 0;
  logic [7:0] mem [256];

  mem_arbiter_if #(.TAG_W(TAG_W)) bus ();

  mem_arbiter #(.TAG_W(TAG_W), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Memory model: writes land at the edge ending the store cycle, reads return one cycle later.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'hA5;
      mem[8'h11] <= 8'h3C;
      bus.i_mem_rdata <= 8'h00;
    end else if (bus.o_mem_en) begin
      if (bus.o_mem_wr) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      else bus.i_mem_rdata <= mem[bus.o_mem_addr];
    end
  end

  task automatic applyStimulus(input logic ldV, input logic [7:0] ldA, input logic [TAG_W-1:0] ldT,
                               input logic stV, input logic [7:0] stA, input logic [7:0] stD,
                               input logic fl);
    bus.i_ld_valid = ldV;
    bus.i_ld_addr  = ldA;
    bus.i_ld_tag   = ldT;
    bus.i_st_valid = stV;
    bus.i_st_addr  = stA;
    bus.i_st_data  = stD;
    bus.i_flush    = fl;
    #1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 8'h10, 3'd0, 1'b1, 8'h20, 8'h55, 1'b0);
      assertCount++;
      if ({bus.o_ld_ready, bus.o_st_ready, bus.o_mem_en, bus.o_ld_resp_valid} !== 4'b0000) begin
        failCount++;
        $display("[TB] FAIL reset_ctrl: got %b want 0000", {bus.o_ld_ready, bus.o_st_ready, bus.o_mem_en, bus.o_ld_resp_valid});
      end
      assertCount++;
      if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_ld_resp_data} !== 24'h0) begin
        failCount++;
        $display("[TB] FAIL reset_data: got %h want 000000", {bus.o_mem_addr, bus.o_mem_wdata, bus.o_ld_resp_data});
      end
      nextCycle();
    end
    rst = 1'b0;
    applyStimulus(1'b1, 8'h10, 3'd0, 1'b1, 8'h20, 8'h55, 1'b0);
    assertCount++;
    if ({bus.o_ld_ready, bus.o_st_ready, bus.o_mem_addr} !== {2'b10, 8'h10}) begin
      failCount++;
      $display("[TB] FAIL first_grant: got %b/%h want 10/10", {bus.o_ld_ready, bus.o_st_ready}, bus.o_mem_addr);
    end
    nextCycle();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_resp_valid, bus.o_ld_resp_data} !== {1'b1, 8'hA5}) begin
      failCount++;
      $display("[TB] FAIL first_resp: got %b/%h want 1/a5", bus.o_ld_resp_valid, bus.o_ld_resp_data);
    end
    nextCycle();
  endtask

  task automatic test_load_stream();
    applyStimulus(1'b1, 8'h10, 3'd1, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_ready, bus.o_mem_en, bus.o_mem_wr, bus.o_mem_addr} !== {3'b110, 8'h10}) begin
      failCount++;
      $display("[TB] FAIL ld0_issue: got %b/%h want 110/10", {bus.o_ld_ready, bus.o_mem_en, bus.o_mem_wr}, bus.o_mem_addr);
    end
    nextCycle();
    applyStimulus(1'b1, 8'h11, 3'd2, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_ready, bus.o_mem_addr} !== {1'b1, 8'h11}) begin
      failCount++;
      $display("[TB] FAIL ld1_issue: got %b/%h want 1/11", bus.o_ld_ready, bus.o_mem_addr);
    end
    assertCount++;
    if ({bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data} !== {1'b1, 3'd1, 8'hA5}) begin
      failCount++;
      $display("[TB] FAIL ld0_resp: got %b/%0d/%h want 1/1/a5", bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data);
    end
    nextCycle();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data} !== {1'b1, 3'd2, 8'h3C}) begin
      failCount++;
      $display("[TB] FAIL ld1_resp: got %b/%0d/%h want 1/2/3c", bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data);
    end
    nextCycle();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if (bus.o_ld_resp_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL stream_end: got %b want 0", bus.o_ld_resp_valid);
    end
    nextCycle();
  endtask

  task automatic test_starvation();
    logic [1:0] wantGrant;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h50 + 8'(i), 3'(i), 1'b1, 8'h40, 8'h77, 1'b0);
      wantGrant = (i < 4) ? 2'b10 : 2'b01;
      assertCount++;
      if ({bus.o_ld_ready, bus.o_st_ready} !== wantGrant) begin
        failCount++;
        $display("[TB] FAIL starve_grant%0d: got %b want %b", i, {bus.o_ld_ready, bus.o_st_ready}, wantGrant);
      end
      assertCount++;
      if (dut.r_starve_cnt !== 3'(i)) begin
        failCount++;
        $display("[TB] FAIL starve_cnt%0d: got %0d want %0d", i, dut.r_starve_cnt, i);
      end
      nextCycle();
    end
    applyStimulus(1'b1, 8'h40, 3'd5, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_ready, dut.r_starve_cnt} !== {1'b1, 3'd0}) begin
      failCount++;
      $display("[TB] FAIL starve_after: got %b/%0d want 1/0", bus.o_ld_ready, dut.r_starve_cnt);
    end
    nextCycle();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data} !== {1'b1, 3'd5, 8'h77}) begin
      failCount++;
      $display("[TB] FAIL starve_readback: got %b/%0d/%h want 1/5/77", bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data);
    end
    nextCycle();
  endtask

  task automatic test_collision();
    applyStimulus(1'b1, 8'h22, 3'd3, 1'b1, 8'h22, 8'h5A, 1'b0);
    assertCount++;
    if ({bus.o_ld_ready, bus.o_st_ready, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata} !== {3'b011, 8'h22, 8'h5A}) begin
      failCount++;
      $display("[TB] FAIL coll_store: got %b/%h/%h want 011/22/5a", {bus.o_ld_ready, bus.o_st_ready, bus.o_mem_wr}, bus.o_mem_addr, bus.o_mem_wdata);
    end
    nextCycle();
    applyStimulus(1'b1, 8'h22, 3'd3, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_ready, dut.r_starve_cnt} !== {1'b1, 3'd0}) begin
      failCount++;
      $display("[TB] FAIL coll_load: got %b/%0d want 1/0", bus.o_ld_ready, dut.r_starve_cnt);
    end
    nextCycle();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data} !== {1'b1, 3'd3, 8'h5A}) begin
      failCount++;
      $display("[TB] FAIL coll_resp: got %b/%0d/%h want 1/3/5a", bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data);
    end
    nextCycle();
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 8'h10, 3'd4, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if (bus.o_ld_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL flush_pre_load: got %b want 1", bus.o_ld_ready);
    end
    nextCycle();
    applyStimulus(1'b1, 8'h11, 3'd6, 1'b1, 8'h30, 8'h99, 1'b1);
    assertCount++;
    if ({bus.o_ld_resp_valid, bus.o_ld_resp_data, bus.o_ld_ready, bus.o_st_ready} !== {1'b0, 8'h00, 2'b01}) begin
      failCount++;
      $display("[TB] FAIL flush_cycle: got %b/%h/%b want 0/00/01", bus.o_ld_resp_valid, bus.o_ld_resp_data, {bus.o_ld_ready, bus.o_st_ready});
    end
    nextCycle();
    applyStimulus(1'b1, 8'h11, 3'd6, 1'b0, 8'h00, 8'h00, 1'b1);
    assertCount++;
    if ({bus.o_ld_ready, bus.o_mem_en} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL flush_ld_block: got %b want 00", {bus.o_ld_ready, bus.o_mem_en});
    end
    nextCycle();
    applyStimulus(1'b1, 8'h30, 3'd6, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_ready, bus.o_ld_resp_valid} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL flush_resume: got %b want 10", {bus.o_ld_ready, bus.o_ld_resp_valid});
    end
    nextCycle();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data} !== {1'b1, 3'd6, 8'h99}) begin
      failCount++;
      $display("[TB] FAIL flush_store_resp: got %b/%0d/%h want 1/6/99", bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_resp_data);
    end
    nextCycle();
  endtask

  task automatic test_reset_midop();
    applyStimulus(1'b1, 8'h11, 3'd7, 1'b0, 8'h00, 8'h00, 1'b0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 8'h12, 3'd1, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_ready} !== {1'b0, 3'd0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL midop_rst: got %b/%0d/%b want 0/0/0", bus.o_ld_resp_valid, bus.o_ld_resp_tag, bus.o_ld_ready);
    end
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    assertCount++;
    if ({bus.o_ld_resp_valid, bus.o_ld_resp_tag} !== {1'b0, 3'd0}) begin
      failCount++;
      $display("[TB] FAIL midop_after: got %b/%0d want 0/0", bus.o_ld_resp_valid, bus.o_ld_resp_tag);
    end
    nextCycle();
  endtask

  task automatic test_idle();
    applyStimulus(1'b1, 8'h60, 3'd2, 1'b1, 8'h61, 8'hC3, 1'b0);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      assertCount++;
      if ({bus.o_mem_en, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata} !== 18'h0) begin
        failCount++;
        $display("[TB] FAIL idle_mem%0d: got %b/%h/%h want 0/00/00", k, bus.o_mem_en, bus.o_mem_addr, bus.o_mem_wdata);
      end
      assertCount++;
      if (dut.r_starve_cnt !== ((k == 0) ? 3'd1 : 3'd0)) begin
        failCount++;
        $display("[TB] FAIL idle_cnt%0d: got %0d want %0d", k, dut.r_starve_cnt, (k == 0) ? 1 : 0);
      end
      nextCycle();
    end
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    nextCycle();
    test_reset();
    test_load_stream();
    test_starvation();
    test_collision();
    test_flush();
    test_reset_midop();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
